// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, issues word-aligned instruction memory requests
// and buffers returned words for decode; a redirect flushes buffered and in-flight work.
//
// state | meaning
// IDLE  | first cycle after reset release, no requests issued
// RUN   | normal fetch
// FLUSH | stale responses from before a redirect are still outstanding
module instr_fetch #(
    parameter int                   AddrWidth   = 32,
    parameter int                   InstrWidth  = 32,
    parameter logic [AddrWidth-1:0] ResetVector = '0,
    parameter int                   FifoDepth   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pcWriteEnable,
    input  logic [AddrWidth-1:0]  pcWriteData,
    output logic                  imemReqValid,
    input  logic                  imemReqReady,
    output logic [AddrWidth-1:0]  imemReqAddr,
    input  logic                  imemRespValid,
    input  logic [InstrWidth-1:0] imemRespData,
    output logic                  instrValid,
    input  logic                  instrReady,
    output logic [InstrWidth-1:0] instr,
    output logic [AddrWidth-1:0]  pcReadData
);
    localparam int CW = $clog2(FifoDepth + 1);
    localparam int PW = $clog2(FifoDepth);
    localparam logic [CW:0] DEPTH = FifoDepth[CW:0];

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                state, state_nxt;
    logic [AddrWidth-1:0]  fetch_pc;
    logic [CW-1:0]         inflight, discard, discard_nxt, fifo_count;
    logic [CW:0]           used;
    logic                  pop, req_fire, keep;

    logic [AddrWidth-1:0]  pcq [FifoDepth];
    logic [PW-1:0]         pcq_wr, pcq_rd;
    logic [InstrWidth-1:0] fifo_instr [FifoDepth];
    logic [AddrWidth-1:0]  fifo_pc [FifoDepth];
    logic [PW-1:0]         fifo_wr, fifo_rd;
    logic [InstrWidth-1:0] last_instr;
    logic [AddrWidth-1:0]  last_pc;

    assign instrValid = (fifo_count != '0);
    assign pop        = instrValid && instrReady && !pcWriteEnable;
    // A slot freed by this cycle's pop counts as credit, so a 1-cycle memory streams back to back.
    assign used       = {1'b0, inflight} + {1'b0, fifo_count} - (CW+1)'(pop);

    assign imemReqValid = (state != IDLE) && !pcWriteEnable && (used < DEPTH);
    assign imemReqAddr  = fetch_pc;
    assign req_fire     = imemReqValid && imemReqReady;
    assign keep         = imemRespValid && !pcWriteEnable && (discard == '0);

    assign instr      = instrValid ? fifo_instr[fifo_rd] : last_instr;
    assign pcReadData = instrValid ? fifo_pc[fifo_rd]    : last_pc;

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        if (pcWriteEnable)
            discard_nxt = inflight - CW'(imemRespValid);
        else if (imemRespValid && (discard != '0))
            discard_nxt = discard - CW'(1);
        case (state)
            IDLE:       state_nxt = RUN;
            RUN, FLUSH: begin
                if (pcWriteEnable)
                    state_nxt = (discard_nxt != '0) ? FLUSH : RUN;
                else if (state == FLUSH && discard_nxt == '0)
                    state_nxt = RUN;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            discard    <= '0;
            fetch_pc   <= ResetVector;
            inflight   <= '0;
            pcq_wr     <= '0;
            pcq_rd     <= '0;
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            fifo_count <= '0;
            last_instr <= '0;
            last_pc    <= '0;
        end else begin
            state    <= state_nxt;
            discard  <= discard_nxt;
            inflight <= inflight + CW'(req_fire) - CW'(imemRespValid);
            if (pcWriteEnable)
                fetch_pc <= pcWriteData & ~AddrWidth'(3);
            else if (req_fire)
                fetch_pc <= fetch_pc + AddrWidth'(4);
            // PC queue stays in lockstep with inflight; stale responses consume their entries.
            if (req_fire)
                pcq_wr <= pcq_wr + PW'(1);
            if (imemRespValid)
                pcq_rd <= pcq_rd + PW'(1);
            if (instrValid) begin
                last_instr <= fifo_instr[fifo_rd];
                last_pc    <= fifo_pc[fifo_rd];
            end
            if (pcWriteEnable) begin
                fifo_wr    <= '0;
                fifo_rd    <= '0;
                fifo_count <= '0;
            end else begin
                if (keep)
                    fifo_wr <= fifo_wr + PW'(1);
                if (pop)
                    fifo_rd <= fifo_rd + PW'(1);
                fifo_count <= fifo_count + CW'(keep) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            pcq[pcq_wr] <= fetch_pc;
        if (keep) begin
            fifo_instr[fifo_wr] <= imemRespData;
            fifo_pc[fifo_wr]    <= pcq[pcq_rd];
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: fixed-latency in-order memory model plus a delivery scoreboard.
module tb_instr_fetch;
    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcWriteEnable;
    logic [31:0] pcWriteData;
    logic        imemReqValid;
    logic        imemReqReady;
    logic [31:0] imemReqAddr;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [31:0] pcReadData;

    always #5 clk = ~clk;

    instr_fetch #(
        .AddrWidth(32), .InstrWidth(32), .ResetVector(RV), .FifoDepth(2)
    ) dut (
        .clk(clk), .reset(reset),
        .pcWriteEnable(pcWriteEnable), .pcWriteData(pcWriteData),
        .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemReqAddr(imemReqAddr),
        .imemRespValid(imemRespValid), .imemRespData(imemRespData),
        .instrValid(instrValid), .instrReady(instrReady),
        .instr(instr), .pcReadData(pcReadData)
    );

    typedef struct {logic [31:0] addr; int due;} mreq_t;
    typedef struct {logic [31:0] instr; logic [31:0] pc;} exp_t;
    typedef struct {int lat; int off; logic [31:0] target; logic [31:0] first; logic [31:0] second;} vec_t;

    mreq_t       memq[$];
    exp_t        expq[$];
    logic [31:0] del_pc[$];
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    int          cyc = 0, rel_cyc = 0, lat = 1, n_tests = 0, n_fail = 0, n_del = 0, first_valid_cyc = -1;
    logic [31:0] exp_addr;
    logic        prev_stall, prev_redir;
    logic [31:0] prev_instr, prev_pc;
    vec_t        vecs[4];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One clock: sample at negedge, then drive memory response just after posedge.
    task automatic step();
        exp_t  e;
        mreq_t m;
        @(negedge clk);
        if (reset) begin
            if (prev_redir) check("valid_after_redirect", 32'(instrValid), 32'h0);
            if (prev_stall && instrValid) begin
                check("hold_instr", instr, prev_instr);
                check("hold_pc", pcReadData, prev_pc);
            end
            if (instrValid && instrReady && !pcWriteEnable) begin
                n_del++;
                del_pc.push_back(pcReadData);
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (expq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_delivery: got pc %h with nothing expected", pcReadData);
                end else begin
                    e = expq.pop_front();
                    check("deliver_pc", pcReadData, e.pc);
                    check("deliver_instr", instr, e.instr);
                end
            end
            if (imemReqValid && imemReqReady) begin
                check("req_addr", imemReqAddr, exp_addr);
                acc_addr.push_back(imemReqAddr);
                acc_cyc.push_back(cyc);
                memq.push_back('{addr: imemReqAddr, due: cyc + lat});
                expq.push_back('{instr: mem_word(imemReqAddr), pc: imemReqAddr});
                exp_addr = exp_addr + 32'd4;
            end
            if (pcWriteEnable) begin
                check("redirect_no_req", 32'(imemReqValid), 32'h0);
                expq.delete();
                del_pc.delete();
                exp_addr = pcWriteData & ~32'h3;
            end
            prev_stall = instrValid && !instrReady && !pcWriteEnable;
            prev_redir = pcWriteEnable;
            prev_instr = instr;
            prev_pc    = pcReadData;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            m = memq.pop_front();
            imemRespValid = 1'b1;
            imemRespData  = mem_word(m.addr);
        end else begin
            imemRespValid = 1'b0;
            imemRespData  = 32'h0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_until(input int off);
        while (cyc < rel_cyc + off) step();
    endtask

    task automatic redirect(input int off, input logic [31:0] target);
        run_until(off);
        pcWriteEnable = 1'b1;
        pcWriteData   = target;
        step();
        pcWriteEnable = 1'b0;
    endtask

    task automatic do_reset(input int l, input bit chk);
        reset         = 1'b0;
        pcWriteEnable = 1'b0;
        pcWriteData   = 32'h0;
        imemRespValid = 1'b0;
        imemRespData  = 32'h0;
        imemReqReady  = 1'b1;
        instrReady    = 1'b1;
        memq.delete(); expq.delete(); del_pc.delete(); acc_addr.delete(); acc_cyc.delete();
        prev_stall = 1'b0; prev_redir = 1'b0;
        n_del = 0; first_valid_cyc = -1; lat = l; exp_addr = RV;
        repeat (2) @(posedge clk);
        #1;
        if (chk) begin
            check("rst_req_valid", 32'(imemReqValid), 32'h0);
            check("rst_req_addr", imemReqAddr, RV);
            check("rst_instr_valid", 32'(instrValid), 32'h0);
            check("rst_instr", instr, 32'h0);
            check("rst_pc", pcReadData, 32'h0);
        end
        reset   = 1'b1;
        rel_cyc = cyc;
    endtask

    initial begin
        vecs[0] = '{lat: 3, off: 3, target: 32'h0000_2003, first: 32'h0000_2000, second: 32'h0000_2004};
        vecs[1] = '{lat: 3, off: 4, target: 32'h0000_3000, first: 32'h0000_3000, second: 32'h0000_3004};
        vecs[2] = '{lat: 1, off: 5, target: 32'h0000_0007, first: 32'h0000_0004, second: 32'h0000_0008};
        vecs[3] = '{lat: 2, off: 4, target: 32'hFFFF_FFFF, first: 32'hFFFF_FFFC, second: 32'h0000_0000};

        // Startup latency and streaming with a 1-cycle memory.
        do_reset(1, 1'b1);
        run(8);
        if (acc_addr.size() >= 3) begin
            check("start_addr0", acc_addr[0], 32'h100);
            check("start_addr2", acc_addr[2], 32'h108);
            check("start_acc0_cyc", 32'(acc_cyc[0] - rel_cyc), 32'd1);
            check("start_acc2_cyc", 32'(acc_cyc[2] - rel_cyc), 32'd3);
        end else fail_now("start_accepts", acc_addr.size(), 3);
        check("start_first_valid", 32'(first_valid_cyc - rel_cyc), 32'd3);
        check("start_deliveries", 32'(n_del), 32'd5);
        if (del_pc.size() > 0) check("start_first_pc", del_pc[0], 32'h100);

        // Backpressure: credit stops requests at FIFO depth, head held.
        do_reset(1, 1'b0);
        instrReady = 1'b0;
        run(12);
        check("bp_accepts", 32'(acc_addr.size()), 32'd2);
        check("bp_req_valid", 32'(imemReqValid), 32'h0);
        check("bp_head_valid", 32'(instrValid), 32'h1);
        check("bp_head_pc", pcReadData, 32'h100);
        check("bp_head_instr", instr, mem_word(32'h100));
        instrReady = 1'b1;
        run(10);
        if (del_pc.size() >= 3) begin
            check("bp_order0", del_pc[0], 32'h100);
            check("bp_order1", del_pc[1], 32'h104);
            check("bp_order2", del_pc[2], 32'h108);
        end else fail_now("bp_deliveries", del_pc.size(), 3);

        // Redirect table: in-flight drop, coincident response, pop-cycle redirect, wrap.
        for (int i = 0; i < 4; i++) begin
            do_reset(vecs[i].lat, 1'b0);
            redirect(vecs[i].off, vecs[i].target);
            run(20);
            if (del_pc.size() >= 2) begin
                check($sformatf("redir%0d_first_pc", i), del_pc[0], vecs[i].first);
                check($sformatf("redir%0d_second_pc", i), del_pc[1], vecs[i].second);
            end else fail_now($sformatf("redir%0d_deliveries", i), del_pc.size(), 2);
        end

        // Second redirect while the first target's request is still stale in flight.
        do_reset(3, 1'b0);
        redirect(2, 32'h0000_0400);
        redirect(4, 32'h0000_0800);
        run(20);
        if (del_pc.size() >= 1) check("dbl_first_pc", del_pc[0], 32'h800);
        else fail_now("dbl_deliveries", del_pc.size(), 1);

        // Asynchronous reset mid-burst.
        do_reset(1, 1'b0);
        run(8);
        check("pre_reset_req_valid", 32'(imemReqValid), 32'h1);
        check("pre_reset_instr_valid", 32'(instrValid), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("async_req_valid", 32'(imemReqValid), 32'h0);
        check("async_instr_valid", 32'(instrValid), 32'h0);
        check("async_req_addr", imemReqAddr, RV);
        do_reset(1, 1'b0);
        run(6);
        if (del_pc.size() >= 1) check("post_reset_first_pc", del_pc[0], 32'h100);
        else fail_now("post_reset_deliveries", del_pc.size(), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
